// File: rtl/common.sv
// Shared NOS definitions: word-length select and its bit count.
package common;

    typedef enum logic [1:0] {
        NOS16 = 2'd0,
        NOS18 = 2'd1,
        NOS20 = 2'd2,
        NOS24 = 2'd3
    } NOS_BITNUM;

    localparam int unsigned NosShiftW = 24;
    localparam int unsigned NosCntW   = 6;

    function automatic logic [NosCntW-1:0] nos_bits(input NOS_BITNUM sel);
        logic [NosCntW-1:0] n;
        case (sel)
            NOS16:   n = 6'd16;
            NOS18:   n = 6'd18;
            NOS20:   n = 6'd20;
            default: n = 6'd24;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/nos_full_rx_sync.sv
// 2-flop synchronizer with registered edge detect; sync_o is delayed to line up with the edges.
module nos_rx_sync #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Width-1:0] async_i,
    output logic [Width-1:0] sync_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    logic [Width-1:0] meta_q, sync_q, dly_q, rise_q, fall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            rise_q <= sync_q & ~dly_q;
            fall_q <= ~sync_q & dly_q;
        end
    end

    assign sync_o = dly_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/nos_full_rx.sv
// NOS full-mode serial receiver: shifts L/R on bck, captures the last N bits on le fall.
// Optional bit-count check is enabled by defining NOS_RX_BITCNT_CHECK_EN.
module nos_full_rx
    import common::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        en_i,
    input  NOS_BITNUM   nos_bitnum_i,
    input  logic        bck_i,
    input  logic        data_l_i,
    input  logic        data_r_i,
    input  logic        le_i,
    output logic [63:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overrun_o,
    output logic        frame_err_o
);

    typedef enum logic [1:0] {StIdle, StShift, StCapture} rx_state_e;

    localparam int unsigned IdxBck = 0;
    localparam int unsigned IdxL   = 1;
    localparam int unsigned IdxR   = 2;
    localparam int unsigned IdxLe  = 3;

    rx_state_e state_q, state_d;
    logic [NosShiftW-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [NosCntW-1:0]   cnt_q, cnt_d;
    logic [63:0]          data_q, data_d;
    logic                 valid_q, valid_d, overrun_q, overrun_d;

    logic [3:0] sync_w, rise_w, fall_w;
    logic       bck_rise, le_fall, capture;
    logic [NosCntW-1:0] n_bits;
    logic       unused_sync;

    nos_rx_sync #(
        .Width (4)
    ) u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .async_i ({le_i, data_r_i, data_l_i, bck_i}),
        .sync_o  (sync_w),
        .rise_o  (rise_w),
        .fall_o  (fall_w)
    );

    assign bck_rise    = rise_w[IdxBck];
    assign le_fall     = fall_w[IdxLe];
    assign unused_sync = ^{sync_w[IdxBck], sync_w[IdxLe], rise_w[3:1], fall_w[2:0]};

    assign capture = en_i && (state_q == StCapture);
    assign n_bits  = nos_bits(nos_bitnum_i);

    // Last N shifted bits, MSB-justified in a 32-bit slot.
    function automatic logic [31:0] justify(input logic [NosShiftW-1:0] sh,
                                            input logic [NosCntW-1:0] n);
        logic [31:0] full;
        full = {sh, 8'h00};
        return full << (6'd24 - n);
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bck_rise) state_d = StShift;
            StShift:   if (le_fall) state_d = StCapture;
            StCapture: state_d = StShift;
            default:   state_d = StIdle;
        endcase
        if (!en_i) state_d = StIdle;
    end

    // Capture reads the registered shift state, so a bit shifted together with le fall is included.
    always_comb begin
        sh_l_d = sh_l_q;
        sh_r_d = sh_r_q;
        cnt_d  = cnt_q;
        if (!en_i) begin
            sh_l_d = '0;
            sh_r_d = '0;
            cnt_d  = '0;
        end else begin
            if (bck_rise) begin
                sh_l_d = {sh_l_q[NosShiftW-2:0], sync_w[IdxL]};
                sh_r_d = {sh_r_q[NosShiftW-2:0], sync_w[IdxR]};
            end
            if (state_q == StCapture) begin
                cnt_d = bck_rise ? 6'd1 : 6'd0;
            end else if (bck_rise && (cnt_q != 6'h3f)) begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && ready_i) valid_d = 1'b0;
        if (capture) begin
            if (!valid_q || ready_i) begin
                data_d  = {justify(sh_l_q, n_bits), justify(sh_r_q, n_bits)};
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (!en_i) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            sh_l_q    <= '0;
            sh_r_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_l_q    <= sh_l_d;
            sh_r_q    <= sh_r_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef NOS_RX_BITCNT_CHECK_EN
    logic ferr_q, ferr_d;

    assign ferr_d = capture && (cnt_q < n_bits);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ferr_q <= 1'b0;
        else         ferr_q <= ferr_d;
    end

    assign frame_err_o = ferr_q;
`else
    assign frame_err_o = 1'b0;
`endif

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_nos_full_rx.sv
// Randomized bench for nos_full_rx: behavioural serial transmitter plus bit-history reference model.
`timescale 1ns/1ps
module tb_nos_full_rx;
    import common::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en_i = 1'b1;
    NOS_BITNUM   nos_bitnum_i = NOS24;
    logic        bck_i = 1'b0;
    logic        data_l_i = 1'b0;
    logic        data_r_i = 1'b0;
    logic        le_i = 1'b0;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        overrun_o;
    logic        frame_err_o;

    always #5 clk = ~clk;

    nos_full_rx dut (
        .clk          (clk),
        .resetn       (resetn),
        .en_i         (en_i),
        .nos_bitnum_i (nos_bitnum_i),
        .bck_i        (bck_i),
        .data_l_i     (data_l_i),
        .data_r_i     (data_r_i),
        .le_i         (le_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overrun_o    (overrun_o),
        .frame_err_o  (frame_err_o)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: every bit shifted since reset/disable, newest at the back.
    bit          hist_l[$];
    bit          hist_r[$];
    int          since_cap = 0;
    logic [63:0] exp_data[$];
    logic        exp_ferr[$];
    logic [63:0] got_data[$];
    logic        got_ferr[$];

    function automatic int bits_of(input NOS_BITNUM b);
        case (b)
            NOS16:   return 16;
            NOS18:   return 18;
            NOS20:   return 20;
            default: return 24;
        endcase
    endfunction

    function automatic logic [31:0] model_slot(input bit h[$], input int n);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < n; k++) begin
            if (h.size() > k) s[32-n+k] = h[h.size()-1-k];
        end
        return s;
    endfunction

    function automatic logic model_ferr(input int cnt, input int n);
`ifdef NOS_RX_BITCNT_CHECK_EN
        return cnt < n;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        hist_l.delete();
        hist_r.delete();
        since_cap = 0;
    endtask

    task automatic model_capture(input bit deliver);
        int n;
        n = bits_of(nos_bitnum_i);
        if (deliver) begin
            exp_data.push_back({model_slot(hist_l, n), model_slot(hist_r, n)});
            exp_ferr.push_back(model_ferr(since_cap, n));
        end
        since_cap = 0;
    endtask

    task automatic send_bits(input logic [31:0] wl, input logic [31:0] wr, input int nbits,
                             input int lead, input bit lead_rand, input int half,
                             input bit simul, input bit do_le, input bit deliver);
        int total_b;
        total_b = lead + nbits;
        for (int i = 0; i < total_b; i++) begin
            bit bl, br, last;
            last = (i == total_b - 1);
            if (i < lead) begin
                bl = lead_rand ? 1'($urandom_range(0, 1)) : 1'b0;
                br = lead_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                bl = wl[nbits-1-(i-lead)];
                br = wr[nbits-1-(i-lead)];
            end
            bck_i = 1'b0;
            data_l_i = bl;
            data_r_i = br;
            if (last && do_le) le_i = 1'b1;
            #(half);
            if (last && do_le && simul) begin
                @(negedge clk);
                le_i = 1'b0;
            end
            bck_i = 1'b1;
            hist_l.push_back(bl);
            hist_r.push_back(br);
            since_cap++;
            #(half);
        end
        bck_i = 1'b0;
        if (do_le) begin
            le_i = 1'b0;
            model_capture(deliver);
        end
        #(half);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_clear();
    endtask

    int valid_long = 0;
    int ferr_long  = 0;
    bit vr_prev    = 1'b0;
    bit ferr_prev  = 1'b0;

    always @(negedge clk) begin
        if (resetn && valid_o && ready_i) begin
            got_data.push_back(data_o);
            got_ferr.push_back(frame_err_o);
        end
        if (valid_o && ready_i && vr_prev) valid_long++;
        if (frame_err_o && ferr_prev) ferr_long++;
        vr_prev   = valid_o && ready_i;
        ferr_prev = frame_err_o;
    end

    task automatic drain_check(input string tag);
        repeat (20) @(negedge clk);
        check({tag, "_count"}, 64'(got_data.size()), 64'(exp_data.size()));
        while (got_data.size() > 0 && exp_data.size() > 0) begin
            check({tag, "_data"}, got_data.pop_front(), exp_data.pop_front());
            check({tag, "_ferr"}, 64'(got_ferr.pop_front()), 64'(exp_ferr.pop_front()));
        end
        got_data.delete();
        got_ferr.delete();
        exp_data.delete();
        exp_ferr.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", data_o, 64'h0);
        check("rst_valid", 64'(valid_o), 64'h0);
        check("rst_overrun", 64'(overrun_o), 64'h0);
        check("rst_ferr", 64'(frame_err_o), 64'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        model_clear();

        // NOS24 basic frame
        nos_bitnum_i = NOS24;
        send_bits(32'hA5A5A5, 32'h5A5A5A, 24, 0, 1'b0, 25, 1'b0, 1'b1, 1'b0);
        exp_data.push_back(64'hA5A5A500_5A5A5A00);
        exp_ferr.push_back(1'b0);
        drain_check("nos24");

        // NOS16 with 24 leading zero bits
        nos_bitnum_i = NOS16;
        send_bits(32'h8001, 32'h7FFE, 16, 24, 1'b0, 23, 1'b0, 1'b1, 1'b0);
        exp_data.push_back(64'h80010000_7FFE0000);
        exp_ferr.push_back(1'b0);
        drain_check("nos16_cont");

        // le fall coincident with last bck rise
        nos_bitnum_i = NOS20;
        send_bits($urandom, $urandom, 20, 0, 1'b0, 27, 1'b1, 1'b1, 1'b1);
        drain_check("simul");

        // short NOS20 frame: 12 bits on top of a cleared shift register
        do_reset();
        nos_bitnum_i = NOS20;
        send_bits(32'hABC, 32'h5A3, 12, 0, 1'b0, 25, 1'b0, 1'b1, 1'b0);
        exp_data.push_back(64'h00ABC000_005A3000);
`ifdef NOS_RX_BITCNT_CHECK_EN
        exp_ferr.push_back(1'b1);
`else
        exp_ferr.push_back(1'b0);
`endif
        drain_check("short");

        // reset in the middle of a frame, then a full frame
        nos_bitnum_i = NOS24;
        send_bits(32'hFFFFFF, 32'hFFFFFF, 10, 0, 1'b0, 25, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_bits(32'h123456, 32'h654321, 24, 0, 1'b0, 25, 1'b0, 1'b1, 1'b0);
        exp_data.push_back(64'h12345600_65432100);
        exp_ferr.push_back(1'b0);
        drain_check("midrst");

        // overrun: two NOS18 frames with ready low
        nos_bitnum_i = NOS18;
        @(posedge clk);
        #1 ready_i = 1'b0;
        send_bits(32'h3FFFF, 32'h3FFFF, 18, 0, 1'b0, 25, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("ovr_first_data", data_o, 64'hFFFFC000_FFFFC000);
        check("ovr_first_flag", 64'(overrun_o), 64'h0);
        send_bits(32'h00001, 32'h00001, 18, 0, 1'b0, 25, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("ovr_hold_data", data_o, 64'hFFFFC000_FFFFC000);
        check("ovr_hold_valid", 64'(valid_o), 64'h1);
        check("ovr_flag", 64'(overrun_o), 64'h1);
        exp_data.push_back(64'hFFFFC000_FFFFC000);
        exp_ferr.push_back(1'b0);
        @(posedge clk);
        #1 ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_valid_drop", 64'(valid_o), 64'h0);
        check("ovr_sticky", 64'(overrun_o), 64'h1);
        #1 en_i = 1'b0;
        @(posedge clk);
        #1 en_i = 1'b1;
        model_clear();
        @(negedge clk);
        check("ovr_clear", 64'(overrun_o), 64'h0);
        drain_check("ovr");

        // randomized frames for every word length
        for (int b = 0; b < 4; b++) begin
            for (int f = 0; f < 6; f++) begin
                int nb;
                nos_bitnum_i = NOS_BITNUM'(b[1:0]);
                nb = bits_of(nos_bitnum_i);
                send_bits($urandom, $urandom, nb, $urandom_range(8, 0), 1'b1,
                          $urandom_range(37, 20), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            end
            drain_check("rand");
        end

        check("valid_width", 64'(valid_long), 64'h0);
        check("ferr_width", 64'(ferr_long), 64'h0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/nos_full_rx.md
NOS_FULL_RX -- requirements
Module: nos_full_rx

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; resetn  in  1  reset; reset resetn, asynchronous, active-low; clock clk.
REQ-002 SHALL have: en  in  1  receiver enable; low forces IDLE and clears shift/count state.
REQ-003 SHALL have: nos_bitnum  in  NOS_BITNUM  word length select (NOS16/18/20/24), sampled at each capture.
REQ-004 SHALL have: bck_in, data_l_in, data_r_in, le_in  in  1 each  asynchronous NOS full-mode serial lines.
REQ-005 SHALL have: data  out  64  captured frame; [63:32] left, [31:0] right, MSB-justified in each 32-bit slot, unused LSBs zero.
REQ-006 SHALL have: valid  out  1; ready  in  1; overrun  out  1 (sticky); frame_err  out  1 (one-cycle pulse).

Function
REQ-007 SHALL pass all four serial inputs through 2-flop synchronizers; clk SHALL be >= 4x bck frequency.
REQ-008 SHALL detect bck rising edge and le falling edge on synchronized signals, one clk after the second sync flop.
REQ-009 SHALL shift data_l_in/data_r_in MSB-first into two 24-bit shift registers on each bck rising edge, including edges while le high.
REQ-010 SHALL count bck rises since last capture in a 6-bit counter saturating at 63.
REQ-011 FSM states: IDLE, SHIFT, CAPTURE. IDLE->SHIFT on first bck rise with en=1; SHIFT->CAPTURE on le falling edge; CAPTURE->SHIFT unconditionally after one cycle; any state->IDLE when en=0.
REQ-012 In CAPTURE SHALL take the last N shifted bits (N=16/18/20/24 per nos_bitnum), place left at data[63:64-N], right at data[31:32-N], zero remaining bits.
REQ-013 Leading extra bits (bck_cont mode, count > N) SHALL be discarded; only last N bits used.
REQ-014 In CAPTURE counter SHALL reset to 0 and shift registers SHALL be kept (not cleared).
REQ-015 Handshake: data/valid SHALL update in CAPTURE when valid=0 or ready=1 in that cycle; valid SHALL drop the cycle after valid&&ready with no new capture.
REQ-016 If CAPTURE occurs while valid=1 and ready=0, frame SHALL be dropped, data held, overrun set; overrun cleared only by reset or en=0.
REQ-017 Simultaneous bck rise and le fall: bit SHALL be shifted first, then capture includes it.
REQ-018 data SHALL remain stable while valid=1 and ready=0.

Reset
REQ-019 On resetn low: state IDLE, data=0, valid=0, overrun=0, frame_err=0, counter=0, shift registers=0, synchronizers=0.
REQ-020 Reset mid-frame SHALL discard partial frame; first capture after reset requires fresh le falling edge.

Configuration
REQ-021 NOS_RX_BITCNT_CHECK_EN defined: in CAPTURE, if counter < N, frame_err SHALL pulse one cycle and frame SHALL still be delivered.
REQ-022 NOS_RX_BITCNT_CHECK_EN undefined: frame_err tied 0, no count comparison logic.

Structure
REQ-023 NOS_BITNUM and a function nos_bits(NOS_BITNUM)->N SHALL live in package common; receiver state enum local.
REQ-024 One sub-module nos_rx_sync (2-flop synchronizer + edge detect, parameterized width) SHALL be instantiated for the four inputs.

Verification
REQ-025 NOS24, left 24'hA5A5A5, right 24'h5A5A5A, 24 bck, le on last bit, ready=1 -> data=64'hA5A5A500_5A5A5A00, valid one cycle.
REQ-026 NOS16, left 16'h8001, right 16'h7FFE, 40 bck (bck_cont, 24 leading zeros) -> data=64'h80010000_7FFE0000, frame_err=0.
REQ-027 ready=0, two consecutive NOS18 frames (18'h3FFFF then 18'h00001) -> data shows first frame (64'hFFFFC000_FFFFC000 when both channels 3FFFF), overrun=1.
REQ-028 NOS20 with only 12 bck before le fall, CHECK_EN defined -> frame_err pulses 1 cycle, valid=1; undefined -> frame_err stays 0.
REQ-029 resetn pulsed after 10 of 24 bits, then full NOS24 frame 24'h123456/24'h654321 -> data=64'h12345600_65432100, no spurious valid.
REQ-030 Loopback against nos_dac_full (independent clk, rx clk 4x), random data, all four nos_bitnum -> every received frame equals transmitted data masked to N MSBs.
